// File: rtl/hilo_seq_pkg.sv
// Shared types and constants for the Hi/Lo multiply/divide sequencer.
// Optional divide-by-zero trap is selected by the HILO_SEQ_DIV0_TRAP_EN macro.
package hilo_seq_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MULT = 3'd1,
        DIV  = 3'd2,
        LOAD = 3'd3,
        EXC  = 3'd4
    } hilo_state_t;

    localparam logic HILO_SEL_MULT = 1'b0;
    localparam logic HILO_SEL_DIV  = 1'b1;

    localparam int CNT_W = 8;

endpackage

// File: rtl/hilo_seq_counter.sv
// 8-bit loadable down-counter with asynchronous active-low clear and a zero flag.
// Load has priority over decrement.
module hilo_seq_counter
    import hilo_seq_pkg::*;
(
    input  logic             clock,
    input  logic             i_clear_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic [CNT_W-1:0] o_count,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clock or negedge i_clear_n) begin
        if (!i_clear_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == '0);

endmodule

// File: rtl/hilo_sequencer.sv
// Sequencer for the shared Hi/Lo multiply/divide unit: holds mult_op/div_op for a fixed
// run length, then pulses hilo_load/done. HILO_SEQ_DIV0_TRAP_EN compiles in the divide-by-zero trap.
module hilo_sequencer #(
    parameter int unsigned MULT_CYCLES = 32,
    parameter int unsigned DIV_CYCLES  = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mult_req,
    input  logic        div_req,
    input  logic [31:0] divisor,
    input  logic        abort,
    output logic        mult_op,
    output logic        div_op,
    output logic        hilo_sel,
    output logic        hilo_load,
    output logic        busy,
    output logic        done,
    output logic        divby0
);

    import hilo_seq_pkg::*;

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    hilo_state_t      r_state;
    logic             r_mult_op;
    logic             r_div_op;
    logic             r_hilo_sel;
    logic             r_hilo_load;
    logic             r_busy;
    logic             r_done;
    logic             w_start;
    logic             w_run;
    logic             w_zero;
    logic [CNT_W-1:0] w_load_val;
    logic [CNT_W-1:0] w_count;

    // The counter is reloaded on any accepted request; a trapped divide loads it harmlessly.
    assign w_start    = (r_state == IDLE) && !abort && (mult_req || div_req);
    assign w_load_val = mult_req ? MULT_LOAD : DIV_LOAD;
    assign w_run      = (r_state == MULT) || (r_state == DIV);

    hilo_seq_counter u_counter (
        .clock      (clock),
        .i_clear_n  (reset),
        .i_load     (w_start),
        .i_load_val (w_load_val),
        .i_dec      (w_run && !w_zero),
        .o_count    (w_count),
        .o_zero     (w_zero)
    );

`ifdef HILO_SEQ_DIV0_TRAP_EN
    logic r_divby0;
    logic w_div_zero;
    logic w_unused_count;

    assign w_div_zero     = (divisor == 32'd0);
    assign w_unused_count = ^w_count;
`else
    logic w_unused_inputs;

    assign w_unused_inputs = (^divisor) ^ (^w_count);
`endif

    // Outputs are registered alongside the state so they never depend combinationally on inputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_mult_op   <= 1'b0;
            r_div_op    <= 1'b0;
            r_hilo_sel  <= HILO_SEL_MULT;
            r_hilo_load <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
`ifdef HILO_SEQ_DIV0_TRAP_EN
            r_divby0    <= 1'b0;
`endif
        end else begin
            r_hilo_load <= 1'b0;
            r_done      <= 1'b0;
`ifdef HILO_SEQ_DIV0_TRAP_EN
            r_divby0    <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (abort) begin
                        r_state <= IDLE;
                    end else if (mult_req) begin
                        r_state    <= MULT;
                        r_mult_op  <= 1'b1;
                        r_hilo_sel <= HILO_SEL_MULT;
                        r_busy     <= 1'b1;
`ifdef HILO_SEQ_DIV0_TRAP_EN
                    end else if (div_req && w_div_zero) begin
                        r_state  <= EXC;
                        r_divby0 <= 1'b1;
                        r_busy   <= 1'b1;
`endif
                    end else if (div_req) begin
                        r_state    <= DIV;
                        r_div_op   <= 1'b1;
                        r_hilo_sel <= HILO_SEL_DIV;
                        r_busy     <= 1'b1;
                    end
                end
                MULT, DIV: begin
                    if (abort) begin
                        r_state   <= IDLE;
                        r_mult_op <= 1'b0;
                        r_div_op  <= 1'b0;
                        r_busy    <= 1'b0;
                    end else if (w_zero) begin
                        r_state     <= LOAD;
                        r_mult_op   <= 1'b0;
                        r_div_op    <= 1'b0;
                        r_hilo_load <= 1'b1;
                        r_done      <= 1'b1;
                    end
                end
                LOAD, EXC: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state   <= IDLE;
                    r_mult_op <= 1'b0;
                    r_div_op  <= 1'b0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign mult_op   = r_mult_op;
    assign div_op    = r_div_op;
    assign hilo_sel  = r_hilo_sel;
    assign hilo_load = r_hilo_load;
    assign busy      = r_busy;
    assign done      = r_done;
`ifdef HILO_SEQ_DIV0_TRAP_EN
    assign divby0    = r_divby0;
`else
    assign divby0    = 1'b0;
`endif

endmodule
